pipemem_stage: RTL and testbench
================================

Name: pipemem_stage

Overview:
- MEM stage of the 5-stage pipelined CPU.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a request/acknowledge data-memory port for loads and stores, including byte and halfword lane handling.
- Stalls the pipeline until each access completes, then presents write-back controls, load data and ALU result for the MEM/WB register to latch.

Parameters:
- TIMEOUT, 16, cycles in REQ without dmem_ack before the access is aborted as a bus error.
- CNTW, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mvalid  in  1  EX/MEM holds a valid instruction.
- mwreg  in  1  instruction writes the register file.
- mm2reg  in  1  instruction is a load (result comes from memory).
- mwmem  in  1  instruction is a store.
- msize  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- munsigned  in  1  zero-extend a byte/half load (lbu/lhu).
- malu  in  32  ALU result, which is also the effective address.
- mb  in  32  store data.
- mrn  in  5  destination register number.
- dmem_ack  in  1  memory completes the access this cycle.
- dmem_rdata  in  32  read word; valid only when dmem_ack=1.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  write enable, registered.
- dmem_addr  out  32  word address: {malu[31:2],2'b00}, registered.
- dmem_wdata  out  32  store data replicated across lanes, registered.
- dmem_be  out  4  byte enables, registered.
- mstall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- mwreg_out  out  1  write enable toward MEM/WB.
- mm2reg_out  out  1  load select toward MEM/WB.
- mmo  out  32  extended load data.
- malu_out  out  32  ALU result pass-through.
- mrn_out  out  5  destination register pass-through.
- mexc  out  1  one-cycle pulse: misaligned access or bus error.

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, captured data=0, error flag=0, counter=0.
- While reset is high, mstall, mwreg_out, mm2reg_out and mexc are forced to 0.
- Access = mvalid & (mm2reg | mwmem). If both mm2reg and mwmem are set, the access is treated as a load.
- Alignment: a half access requires malu[0]=0; a word access requires malu[1:0]=0. A byte access is always aligned.

IDLE:
- Non-access: zero-latency pass-through.
  - mstall=0, mmo=0.
  - mwreg_out = mvalid & mwreg.
- Misaligned access:
  - No request is issued.
  - mexc=1 for the cycle; mwreg_out=0; mstall=0.
  - Instruction retires squashed.
- Aligned access:
  - mstall=1 combinationally.
  - Register dmem_req=1, dmem_we=mwmem&~mm2reg, address, wdata and be.
  - Next state REQ; counter cleared.
- Byte enables:
  - byte: be = 1 << malu[1:0].
  - half: be = 0011 if malu[1]=0, else 1100.
  - word: be = 1111.
- wdata: byte = {4{mb[7:0]}}; half = {2{mb[15:0]}}; word = mb.

REQ:
- mstall=1; request outputs held stable.
- On dmem_ack (this includes the first REQ cycle):
  - Capture dmem_rdata.
  - Deassert dmem_req and dmem_we next edge.
  - Go to DONE.
- Without ack: counter increments. When counter reaches TIMEOUT-1 without ack:
  - Drop dmem_req.
  - Set the error flag.
  - Go to DONE.

DONE:
- Lasts exactly one cycle; next state is IDLE.
- mstall=0, so EX/MEM advances and MEM/WB latches this cycle.
- mmo = extracted captured data:
  - Select lane by malu[1:0] (byte) or malu[1] (half).
  - Sign-extend unless munsigned=1.
- If the error flag is set: mexc=1, mwreg_out=0, mmo=0; flag cleared on exit.
- DONE never issues a new request. The instruction present in the following IDLE cycle is the next one.

General rules:
- mm2reg_out, malu_out and mrn_out pass through in all states.
- dmem_ack in IDLE or DONE is ignored.
- Reset asserted mid-access: dmem_req and dmem_we drop immediately (asynchronously), FSM goes to IDLE, and the access is abandoned.

Test Plan:
- Non-access: mvalid=1, mwreg=1, malu=0x1234, no dmem traffic → same cycle mstall=0, mwreg_out=1, malu_out=0x1234, dmem_req stays 0.
- Word load: malu=0x100; ack after 3 REQ cycles with rdata=0xDEADBEEF → mstall=1 for 4 cycles plus DONE; in DONE mmo=0xDEADBEEF, mwreg_out=1.
- Byte load: lb at malu=0x103 with rdata=0x80FFFFFF → mmo=0xFFFFFF80; same as lbu → mmo=0x00000080.
- Half store: sh at malu=0x202, mb=0x0000ABCD → dmem_be=1100, dmem_we=1, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
- Misaligned: lw at 0x101 → no dmem_req, mexc=1 one cycle, mwreg_out=0, mstall=0.
- Timeout and reset: no ack for TIMEOUT cycles → mexc=1 in DONE, mwreg_out=0. Separately, reset raised during REQ → dmem_req=0 immediately, FSM IDLE, mstall=0.

Source files
------------

// File: rtl/pipemem_stage.sv
// MEM stage of the 5-stage pipeline: request/acknowledge data-memory port with byte/half lanes,
// timeout abort, and write-back controls toward the MEM/WB register.
module pipemem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mvalid,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [1:0]  msize,
    input  logic        munsigned,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        mstall,
    output logic        mwreg_out,
    output logic        mm2reg_out,
    output logic [31:0] mmo,
    output logic [31:0] malu_out,
    output logic [4:0]  mrn_out,
    output logic        mexc,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic        access;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // A load wins when both mm2reg and mwmem are set.
    assign access   = mvalid & (mm2reg | mwmem);
    assign is_store = mwmem & ~mm2reg;

    always_comb begin
        misaligned = 1'b0;
        lane_be    = 4'b1111;
        lane_wdata = mb;
        case (msize)
            2'b00: begin
                lane_be    = 4'b0001 << malu[1:0];
                lane_wdata = {4{mb[7:0]}};
            end
            2'b01: begin
                misaligned = malu[0];
                lane_be    = malu[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{mb[15:0]}};
            end
            default: misaligned = |malu[1:0];
        endcase
    end

    always_comb begin
        byte_sel = rdata_q[7:0];
        case (malu[1:0])
            2'b00: byte_sel = rdata_q[7:0];
            2'b01: byte_sel = rdata_q[15:8];
            2'b10: byte_sel = rdata_q[23:16];
            2'b11: byte_sel = rdata_q[31:24];
            default: byte_sel = rdata_q[7:0];
        endcase
        half_sel = malu[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (msize)
            2'b00:   load_ext = {{24{byte_sel[7] & ~munsigned}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~munsigned}}, half_sel};
            default: load_ext = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {malu[31:2], 2'b00};
                    wdata_d = lane_wdata;
                    be_d    = lane_be;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write-back controls are gated off while reset is asserted.
    always_comb begin
        mstall    = 1'b0;
        mwreg_out = 1'b0;
        mexc      = 1'b0;
        mmo       = '0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (access && misaligned) mexc = 1'b1;
                    else if (access)          mstall = 1'b1;
                    else                      mwreg_out = mvalid & mwreg;
                end
                S_REQ: mstall = 1'b1;
                S_DONE: begin
                    if (err_q) begin
                        mexc = 1'b1;
                    end else begin
                        mwreg_out = mvalid & mwreg;
                        mmo       = load_ext;
                    end
                end
                default: mstall = 1'b0;
            endcase
        end
    end

    assign mm2reg_out = mm2reg & ~reset;
    assign malu_out   = malu;
    assign mrn_out    = mrn;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipemem_stage.sv
// Bench for pipemem_stage: directed cases plus randomized instructions checked against
// an arithmetic reference of lane selection, extension and the request/timeout sequence.
module tb_pipemem_stage;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        mvalid, mwreg, mm2reg, mwmem, munsigned;
    logic [1:0]  msize;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_req, dmem_we, mstall, mwreg_out, mm2reg_out, mexc;
    logic [31:0] dmem_addr, dmem_wdata, mmo, malu_out;
    logic [3:0]  dmem_be;
    logic [4:0]  mrn_out;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    pipemem_stage #(.TIMEOUT(TIMEOUT), .CNTW(5)) dut (
        .clock(clock), .reset(reset), .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg),
        .mwmem(mwmem), .msize(msize), .munsigned(munsigned), .malu(malu), .mb(mb),
        .mrn(mrn), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .mstall(mstall), .mwreg_out(mwreg_out),
        .mm2reg_out(mm2reg_out), .mmo(mmo), .malu_out(malu_out), .mrn_out(mrn_out),
        .mexc(mexc), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * off[1])) & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] b);
        if (sz == 2'd0) return (b & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (b & 32'hFFFF) * 32'h0001_0001;
        return b;
    endfunction

    // ack_at: REQ cycle (1-based) on which memory acknowledges; 0 = never (timeout).
    task automatic do_instr(input logic v, input logic wr, input logic ld, input logic st,
                            input logic [1:0] sz, input logic uns, input logic [31:0] alu,
                            input logic [31:0] b, input int ack_at, input logic [31:0] rd);
        logic acc, mis, err;
        logic [4:0] rn;
        rn = 5'($urandom_range(0, 31));
        @(posedge clock); #1;
        mvalid = v; mwreg = wr; mm2reg = ld; mwmem = st; msize = sz; munsigned = uns;
        malu = alu; mb = b; mrn = rn;
        dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        acc = v & (ld | st);
        mis = (sz == 2'd1) ? alu[0] : (sz >= 2'd2) ? (alu[1:0] != 2'b00) : 1'b0;
        @(negedge clock);
        check_val("malu_out", malu_out, alu);
        check_val("mrn_out", 32'(mrn_out), 32'(rn));
        check_val("mm2reg_out", 32'(mm2reg_out), 32'(ld));
        check_val("idle_req", 32'(dmem_req), 0);
        if (!acc) begin
            check_val("pass_stall", 32'(mstall), 0);
            check_val("pass_wreg", 32'(mwreg_out), 32'(v & wr));
            check_val("pass_mmo", mmo, 0);
            check_val("pass_exc", 32'(mexc), 0);
            return;
        end
        if (mis) begin
            check_val("mis_exc", 32'(mexc), 1);
            check_val("mis_stall", 32'(mstall), 0);
            check_val("mis_wreg", 32'(mwreg_out), 0);
            return;
        end
        check_val("issue_stall", 32'(mstall), 1);
        check_val("issue_exc", 32'(mexc), 0);
        err = (ack_at == 0);
        if (ld || err) exp_q.push_back(err ? 32'h0 : ref_load(rd, sz, alu[1:0], uns));
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clock); #1;
            dmem_ack   = (k == ack_at);
            dmem_rdata = (k == ack_at) ? rd : $urandom;
            @(negedge clock);
            check_val("req_req", 32'(dmem_req), 1);
            check_val("req_we", 32'(dmem_we), 32'(st & ~ld));
            check_val("req_addr", dmem_addr, alu & 32'hFFFF_FFFC);
            check_val("req_wdata", dmem_wdata, ref_wdata(sz, b));
            check_val("req_be", 32'(dmem_be), 32'(ref_be(sz, alu[1:0])));
            check_val("req_stall", 32'(mstall), 1);
            check_val("req_exc", 32'(mexc), 0);
            if (k == ack_at) break;
        end
        @(posedge clock); #1;
        dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        @(negedge clock);
        check_val("done_stall", 32'(mstall), 0);
        check_val("done_req", 32'(dmem_req), 0);
        check_val("done_we", 32'(dmem_we), 0);
        check_val("done_exc", 32'(mexc), 32'(err));
        check_val("done_wreg", 32'(mwreg_out), err ? 32'd0 : 32'(wr));
        if (ld || err) check_val("done_mmo", mmo, exp_q.pop_front());
    endtask

    task automatic reset_mid_access();
        @(posedge clock); #1;
        mvalid = 1; mwreg = 1; mm2reg = 1; mwmem = 0; msize = 2'd2; munsigned = 0;
        malu = 32'h300; dmem_ack = 0;
        @(posedge clock); #1;
        @(negedge clock);
        check_val("rst_pre_req", 32'(dmem_req), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_val("rst_req", 32'(dmem_req), 0);
        check_val("rst_we", 32'(dmem_we), 0);
        check_val("rst_stall", 32'(mstall), 0);
        check_val("rst_wreg", 32'(mwreg_out), 0);
        check_val("rst_state", 32'(dbg_state), 0);
        mvalid = 0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_after_state", 32'(dbg_state), 0);
        check_val("rst_after_stall", 32'(mstall), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mvalid = 1; mwreg = 1; mm2reg = 1; mwmem = 0; msize = 2'd2; munsigned = 0;
        malu = 32'h40; mb = 0; mrn = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(negedge clock);
        check_val("reset_req", 32'(dmem_req), 0);
        check_val("reset_we", 32'(dmem_we), 0);
        check_val("reset_addr", dmem_addr, 0);
        check_val("reset_wdata", dmem_wdata, 0);
        check_val("reset_be", 32'(dmem_be), 0);
        check_val("reset_stall", 32'(mstall), 0);
        check_val("reset_wreg", 32'(mwreg_out), 0);
        check_val("reset_m2reg", 32'(mm2reg_out), 0);
        check_val("reset_exc", 32'(mexc), 0);
        mvalid = 0;
        reset = 1'b0;

        do_instr(1, 1, 0, 0, 2'd2, 0, 32'h1234, 0, 1, 0);
        do_instr(1, 1, 1, 0, 2'd2, 0, 32'h100, 0, 3, 32'hDEAD_BEEF);
        do_instr(1, 1, 1, 0, 2'd0, 0, 32'h103, 0, 1, 32'h80FF_FFFF);
        do_instr(1, 1, 1, 0, 2'd0, 1, 32'h103, 0, 2, 32'h80FF_FFFF);
        do_instr(1, 0, 0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 1, 0);
        do_instr(1, 1, 1, 0, 2'd2, 0, 32'h101, 0, 1, 0);
        do_instr(1, 1, 1, 0, 2'd2, 0, 32'h200, 0, 0, 0);
        do_instr(1, 1, 1, 0, 2'd1, 0, 32'h206, 0, TIMEOUT, 32'h8001_7FFF);
        do_instr(1, 1, 1, 1, 2'd3, 0, 32'h20C, 32'h5555, 1, 32'h1234_5678);
        reset_mid_access();

        for (int i = 0; i < 200; i++) begin
            logic [1:0] kind;
            int ack_at;
            kind = 2'($urandom_range(0, 3));
            ack_at = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
            do_instr(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     kind[0], kind[1], 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom, $urandom, ack_at, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
